operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Parametrised successor of the byte-serial operand entry block on the FPGA board.
- Loads NUM_OPS operands of WORD_W bits one DATA_W-bit switch byte per button press, with back-step editing.
- Hands the operands to a downstream arithmetic unit over a valid/ready handshake, captures its result, and exposes a byte-browsable result to the 7-segment display layer.
- Replaces the button-clocked register scheme with a single clock domain and internal button edge detection.

Parameters:
DATA_W, 8, switch byte width; also the display byte width
WORD_W, 32, operand width; must be a multiple of DATA_W
NUM_OPS, 2, number of operands loaded; range 1..8
RES_W, 32, result width; must be a multiple of DATA_W

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_next  in  1  raw "advance" push-button, asynchronous to clk
btn_prev  in  1  raw "back" push-button, asynchronous to clk
data_in  in  DATA_W  switch byte
op_bus  out  NUM_OPS*WORD_W  operands; operand k at bits [k*WORD_W +: WORD_W]
op_valid  out  1  operands are stable and offered downstream
op_ready  in  1  downstream accepts the operands
res_in  in  RES_W  result from the arithmetic unit
res_valid  in  1  res_in is valid, single-cycle strobe
disp_value  out  DATA_W  byte to show on the two low digits
disp_tag  out  4  operand index in LOAD; NUM_OPS in SHOW; 4'hF in ISSUE/WAIT_RES
disp_pos  out  4  1-based byte position shown
busy  out  1  high in ISSUE and WAIT_RES

Behaviour:
- Reset values (async, immediate on rst rise):
  - operand registers, result register, byte_idx and op_idx all 0
  - state LOAD, op_valid 0, busy 0
  - disp_tag 0, disp_pos 1
- Buttons:
  - Each button passes through a 2-FF synchroniser, then a rising-edge detector.
  - Pulse next_p / prev_p is high for exactly one cycle, in the cycle after the second clk edge that samples the raw input high.
  - A held button gives one pulse; no repeat.
  - next_p and prev_p in the same cycle is a "both" event.
- NB_OP = WORD_W/DATA_W; NB_RES = RES_W/DATA_W.
- LOAD:
  - next_p alone: write data_in into byte byte_idx of operand op_idx, little-endian (byte 0 = LSB). Then advance byte_idx.
  - On byte_idx = NB_OP-1: byte_idx -> 0 and op_idx advances.
  - Write to the last byte of the last operand: go to ISSUE.
  - prev_p alone: step back one byte, no write. At op 0 byte 0, no change.
  - both: ignored.
  - Display: disp_value = data_in (live), disp_tag = op_idx, disp_pos = byte_idx+1.
- ISSUE:
  - op_valid = 1; op_bus held stable.
  - Transfer occurs in the cycle where op_valid and op_ready are both 1. Next state is WAIT_RES and op_valid drops the following cycle.
  - op_ready high on ISSUE entry completes in 1 cycle.
  - Buttons ignored.
- WAIT_RES:
  - The first res_valid latches res_in into the result register.
  - Then go to SHOW with byte_idx = 0.
  - res_valid outside WAIT_RES is ignored. Buttons are ignored.
- SHOW:
  - disp_value = result byte byte_idx; disp_tag = NUM_OPS; disp_pos = byte_idx+1.
  - next_p: byte_idx+1, wrapping NB_RES-1 -> 0.
  - prev_p: byte_idx-1, wrapping 0 -> NB_RES-1.
  - both: restart. Clear operands, result, byte_idx and op_idx; go to LOAD.
- ISSUE/WAIT_RES display: disp_value = 0, disp_tag = 4'hF, disp_pos = 0.
- Reset mid-handshake drops op_valid immediately; no partial state survives.

Decomposition:
- Package operand_loader_pkg:
  - state enum {LOAD, ISSUE, WAIT_RES, SHOW}, 2 bits
  - TAG_BUSY = 4'hF
  - byte-count helper function
- Sub-module btn_edge: synchroniser plus edge detector. Ports clk, rst, raw, pulse. Instantiated twice.

Test Plan:
- Load A=0x3F800000 (bytes 00,00,80,3F) and B=0x40000000 (00,00,00,40) with 8 next presses -> op_bus = 0x40000000_3F800000, op_valid=1, busy=1, disp_tag=F.
- Hold op_ready=0 for 5 cycles, then 1 -> op_valid held 5 cycles with op_bus stable, drops 1 cycle after the transfer; state WAIT_RES.
- res_valid with res_in=0x40000000 -> disp_tag=2, disp_pos=1, disp_value=00.
  - 3 next presses -> pos 4, value 40.
  - 1 further next -> pos 1 (wrap).
  - prev at pos 1 -> pos 4.
- In LOAD: enter 0x11, 0x22, then prev, then 0x33 -> A byte1 = 0x33, byte0 = 0x11.
  - prev at op 0 byte 0 -> no change.
  - both pressed -> no write.
- Button held 100 cycles -> exactly one advance.
  - res_valid pulse in LOAD -> ignored.
  - both in SHOW -> LOAD with op_bus=0.
- rst asserted mid-ISSUE -> op_valid=0 and op_bus=0 in the same cycle; state LOAD; disp_pos=1.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared types and helpers for the byte-serial operand loader.
// Holds the controller state encoding and the byte-count helper used by the top.
package operand_loader_pkg;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        SHOW     = 2'd3
    } state_t;

    localparam logic [3:0] TAG_BUSY = 4'hF;

    // Number of unit_w-wide bytes that make up a total_w-wide word.
    function automatic int byte_count(input int total_w, input int unit_w);
        return total_w / unit_w;
    endfunction

endpackage

// File: rtl/operand_loader_btn_edge.sv
// Push-button conditioner: two-flop synchroniser followed by a rising-edge detector.
// The pulse lasts one clk cycle per press, however long the button is held.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~last_q;

endmodule

// File: rtl/operand_loader.sv
// Loads NUM_OPS operands byte by byte from switches, offers them downstream on a
// valid/ready handshake, captures the result and lets the user browse it by byte.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int WORD_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int RES_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_next,
    input  logic                      btn_prev,
    input  logic [DATA_W-1:0]         data_in,
    output logic [NUM_OPS*WORD_W-1:0] op_bus,
    output logic                      op_valid,
    input  logic                      op_ready,
    input  logic [RES_W-1:0]          res_in,
    input  logic                      res_valid,
    output logic [DATA_W-1:0]         disp_value,
    output logic [3:0]                disp_tag,
    output logic [3:0]                disp_pos,
    output logic                      busy
);

    localparam int NB_OP  = byte_count(WORD_W, DATA_W);
    localparam int NB_RES = byte_count(RES_W, DATA_W);
    localparam int OP_IW  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [3:0]       LAST_OP_BYTE  = 4'(NB_OP - 1);
    localparam logic [3:0]       LAST_RES_BYTE = 4'(NB_RES - 1);
    localparam logic [OP_IW-1:0] LAST_OP       = OP_IW'(NUM_OPS - 1);

    logic next_p;
    logic prev_p;

    btn_edge u_next (.clk(clk), .rst(rst), .raw(btn_next), .pulse(next_p));
    btn_edge u_prev (.clk(clk), .rst(rst), .raw(btn_prev), .pulse(prev_p));

    state_t             state_q, state_d;
    logic [3:0]         byte_idx_q, byte_idx_d;
    logic [OP_IW-1:0]   op_idx_q, op_idx_d;
    logic [WORD_W-1:0]  ops_q [NUM_OPS];
    logic [WORD_W-1:0]  ops_d [NUM_OPS];
    logic [RES_W-1:0]   res_q, res_d;

    logic only_next;
    logic only_prev;
    logic both_p;

    assign only_next = next_p & ~prev_p;
    assign only_prev = prev_p & ~next_p;
    assign both_p    = next_p & prev_p;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        op_idx_d   = op_idx_q;
        ops_d      = ops_q;
        res_d      = res_q;
        case (state_q)
            LOAD: begin
                if (only_next) begin
                    for (int k = 0; k < NUM_OPS; k++) begin
                        for (int b = 0; b < NB_OP; b++) begin
                            if (op_idx_q == OP_IW'(k) && byte_idx_q == 4'(b)) begin
                                ops_d[k][b*DATA_W +: DATA_W] = data_in;
                            end
                        end
                    end
                    if (byte_idx_q == LAST_OP_BYTE) begin
                        byte_idx_d = 4'd0;
                        if (op_idx_q == LAST_OP) begin
                            state_d = ISSUE;
                        end else begin
                            op_idx_d = op_idx_q + 1'b1;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end else if (only_prev) begin
                    if (byte_idx_q != 4'd0) begin
                        byte_idx_d = byte_idx_q - 4'd1;
                    end else if (op_idx_q != '0) begin
                        op_idx_d   = op_idx_q - 1'b1;
                        byte_idx_d = LAST_OP_BYTE;
                    end
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    res_d      = res_in;
                    byte_idx_d = 4'd0;
                    state_d    = SHOW;
                end
            end
            SHOW: begin
                // Pressing both buttons together starts a fresh calculation.
                if (both_p) begin
                    for (int k = 0; k < NUM_OPS; k++) begin
                        ops_d[k] = '0;
                    end
                    res_d      = '0;
                    byte_idx_d = 4'd0;
                    op_idx_d   = '0;
                    state_d    = LOAD;
                end else if (only_next) begin
                    byte_idx_d = (byte_idx_q == LAST_RES_BYTE) ? 4'd0 : byte_idx_q + 4'd1;
                end else if (only_prev) begin
                    byte_idx_d = (byte_idx_q == 4'd0) ? LAST_RES_BYTE : byte_idx_q - 4'd1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            byte_idx_q <= 4'd0;
            op_idx_q   <= '0;
            res_q      <= '0;
            for (int k = 0; k < NUM_OPS; k++) begin
                ops_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            op_idx_q   <= op_idx_d;
            res_q      <= res_d;
            ops_q      <= ops_d;
        end
    end

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_bus
        assign op_bus[gi*WORD_W +: WORD_W] = ops_q[gi];
    end

    assign op_valid = (state_q == ISSUE);
    assign busy     = (state_q == ISSUE) || (state_q == WAIT_RES);

    always_comb begin
        disp_value = '0;
        disp_tag   = TAG_BUSY;
        disp_pos   = 4'd0;
        case (state_q)
            LOAD: begin
                disp_value = data_in;
                disp_tag   = 4'(op_idx_q);
                disp_pos   = byte_idx_q + 4'd1;
            end
            SHOW: begin
                for (int b = 0; b < NB_RES; b++) begin
                    if (byte_idx_q == 4'(b)) begin
                        disp_value = res_q[b*DATA_W +: DATA_W];
                    end
                end
                disp_tag = 4'(NUM_OPS);
                disp_pos = byte_idx_q + 4'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: table-driven load/issue/show rounds with an
// operand scoreboard, followed by hand-written editing, button and reset corner cases.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic [7:0]  data_in = '0;
    logic [63:0] op_bus;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] res_in = '0;
    logic        res_valid = 1'b0;
    logic [7:0]  disp_value;
    logic [3:0]  disp_tag;
    logic [3:0]  disp_pos;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q [$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          hold;
    } vec_t;

    vec_t vecs [3];

    operand_loader dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
        .data_in(data_in), .op_bus(op_bus), .op_valid(op_valid), .op_ready(op_ready),
        .res_in(res_in), .res_valid(res_valid), .disp_value(disp_value),
        .disp_tag(disp_tag), .disp_pos(disp_pos), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns #1 after the clock edge on which the design acts on the pulse.
    task automatic press(input logic nxt, input logic prv, input logic [7:0] d);
        repeat (2) tick();
        data_in  = d;
        btn_next = nxt;
        btn_prev = prv;
        repeat (3) tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            press(1'b1, 1'b0, tmp[7:0]);
        end
    endtask

    initial begin
        logic [63:0] held_bus;
        logic [63:0] exp_bus;
        logic        done;

        vecs[0] = '{a: 32'h3F800000, b: 32'h40000000, res: 32'h40000000, hold: 5};
        vecs[1] = '{a: 32'h12345678, b: 32'h9ABCDEF0, res: 32'hDEADBEEF, hold: 0};
        vecs[2] = '{a: 32'hFFFFFFFF, b: 32'h00000001, res: 32'hA55A0FF0, hold: 2};

        #3;
        chk("rst_op_valid", 64'(op_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_op_bus", op_bus, 64'd0);
        chk("rst_disp_tag", 64'(disp_tag), 64'd0);
        chk("rst_disp_pos", 64'(disp_pos), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 3; v++) begin
            load_word(vecs[v].a);
            for (int i = 0; i < 3; i++) begin
                logic [31:0] tmp;
                tmp = vecs[v].b >> (8 * i);
                press(1'b1, 1'b0, tmp[7:0]);
            end
            if (vecs[v].hold == 0) op_ready = 1'b1;
            press(1'b1, 1'b0, vecs[v].b[31:24]);
            exp_q.push_back({vecs[v].b, vecs[v].a});
            chk("issue_op_valid", 64'(op_valid), 64'd1);
            chk("issue_busy", 64'(busy), 64'd1);
            chk("issue_disp_tag", 64'(disp_tag), 64'hF);
            chk("issue_disp_pos", 64'(disp_pos), 64'd0);
            held_bus = op_bus;
            for (int c = 0; c < vecs[v].hold; c++) begin
                tick();
                chk("hold_op_valid", 64'(op_valid), 64'd1);
                chk("hold_op_bus", op_bus, held_bus);
            end
            op_ready = 1'b1;
            done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                if (op_valid && op_ready) begin
                    exp_bus = exp_q.pop_front();
                    $display("xfer vec=%0d op_bus=%h", v, op_bus);
                    chk("xfer_op_bus", op_bus, exp_bus);
                    done = 1'b1;
                end
                tick();
            end
            if (!done) chk("xfer_timeout", 64'd0, 64'd1);
            op_ready = 1'b0;
            chk("post_xfer_op_valid", 64'(op_valid), 64'd0);
            chk("wait_busy", 64'(busy), 64'd1);

            res_in = vecs[v].res;
            res_valid = 1'b1;
            tick();
            res_valid = 1'b0;
            res_in = 32'h0BADF00D;
            chk("show_busy", 64'(busy), 64'd0);
            chk("show_tag", 64'(disp_tag), 64'd2);
            chk("show_pos1", 64'(disp_pos), 64'd1);
            chk("show_byte0", 64'(disp_value), 64'(vecs[v].res[7:0]));
            for (int p = 1; p < 4; p++) begin
                logic [31:0] tmp;
                tmp = vecs[v].res >> (8 * p);
                press(1'b1, 1'b0, 8'h00);
                chk("show_next_pos", 64'(disp_pos), 64'(p + 1));
                chk("show_next_val", 64'(disp_value), 64'(tmp[7:0]));
            end
            press(1'b1, 1'b0, 8'h00);
            chk("show_wrap_pos", 64'(disp_pos), 64'd1);
            press(1'b0, 1'b1, 8'h00);
            chk("show_prevwrap_pos", 64'(disp_pos), 64'd4);
            chk("show_prevwrap_val", 64'(disp_value), 64'(vecs[v].res[31:24]));
            press(1'b1, 1'b1, 8'h00);
            chk("restart_op_bus", op_bus, 64'd0);
            chk("restart_tag", 64'(disp_tag), 64'd0);
            chk("restart_pos", 64'(disp_pos), 64'd1);
            chk("restart_busy", 64'(busy), 64'd0);
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Back-step editing within operand 0.
        press(1'b1, 1'b0, 8'h11);
        press(1'b1, 1'b0, 8'h22);
        press(1'b0, 1'b1, 8'hEE);
        chk("edit_prev_pos", 64'(disp_pos), 64'd2);
        press(1'b1, 1'b0, 8'h33);
        chk("edit_op_bus", op_bus, 64'h3311);
        chk("edit_pos", 64'(disp_pos), 64'd3);
        data_in = 8'h5A;
        #1;
        chk("load_live_value", 64'(disp_value), 64'h5A);

        press(1'b0, 1'b1, 8'h00);
        press(1'b0, 1'b1, 8'h00);
        press(1'b0, 1'b1, 8'h00);
        chk("prev_floor_pos", 64'(disp_pos), 64'd1);
        chk("prev_floor_tag", 64'(disp_tag), 64'd0);
        chk("prev_floor_bus", op_bus, 64'h3311);

        press(1'b1, 1'b1, 8'h55);
        chk("both_load_pos", 64'(disp_pos), 64'd1);
        chk("both_load_bus", op_bus, 64'h3311);

        repeat (2) tick();
        data_in  = 8'h77;
        btn_next = 1'b1;
        repeat (100) tick();
        btn_next = 1'b0;
        repeat (3) tick();
        chk("held_pos", 64'(disp_pos), 64'd2);
        chk("held_bus", op_bus, 64'h3377);

        res_in = 32'hCAFEBABE;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("res_in_load_busy", 64'(busy), 64'd0);
        chk("res_in_load_pos", 64'(disp_pos), 64'd2);
        chk("res_in_load_tag", 64'(disp_tag), 64'd0);

        // Finish loading, then reset in the middle of the handshake.
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 8'(8'hA0 + i));
        chk("crossing_tag", 64'(disp_tag), 64'd1);
        press(1'b1, 1'b0, 8'hA6);
        chk("mid_issue_valid", 64'(op_valid), 64'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(op_valid), 64'd0);
        chk("async_rst_bus", op_bus, 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_pos", 64'(disp_pos), 64'd1);
        chk("async_rst_tag", 64'(disp_tag), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        press(1'b1, 1'b0, 8'h42);
        chk("post_rst_pos", 64'(disp_pos), 64'd2);
        chk("post_rst_bus", op_bus, 64'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
